// File: rtl/inst_fetch_buffer.sv
// Fetch buffer between stage_if and decode: circular queue of {pc, inst} pairs
// with valid/ready hand-off to ID, full back-pressure and branch flush.
module inst_fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_valid,
  input  logic [31:0]              if_pc,
  input  logic [31:0]              if_inst,
  input  logic                     br_ctrl,
  input  logic                     id_ready,
  output logic                     pc_stall,
  output logic                     id_valid,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_inst,
  output logic [$clog2(DEPTH):0]   fb_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full, empty, push, pop;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  // Full blocks push even when a pop happens the same cycle, so pc_stall
  // depends on registered state only.
  assign push = if_valid & ~full & ~br_ctrl;
  assign pop  = ~empty & id_ready & ~br_ctrl;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (br_ctrl) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_d = count_q + CntW'(1);
      else if (pop && !push) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= if_pc;
      inst_mem[wr_ptr_q] <= if_inst;
    end
  end

  always_comb begin
    pc_stall = full;
    id_valid = ~empty;
    fb_count = count_q;
    id_pc    = '0;
    id_inst  = NOP_INST;
    if (!empty) begin
      id_pc   = pc_mem[rd_ptr_q];
      id_inst = inst_mem[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Randomized and directed bench for inst_fetch_buffer, checked against a
// queue-based model of the buffer's behaviour.
module tb_inst_fetch_buffer;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] NOP_INST = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        br_ctrl;
  logic        id_ready;
  logic        pc_stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [2:0]  fb_count;

  int n_total;
  int n_bad;

  logic [63:0] mq[$];
  logic [31:0] popped_pc[$];

  inst_fetch_buffer #(
    .DEPTH    (DEPTH),
    .NOP_INST (NOP_INST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .br_ctrl  (br_ctrl),
    .id_ready (id_ready),
    .pc_stall (pc_stall),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .fb_count (fb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic        ev;
    logic [31:0] epc, einst;
    ev    = (mq.size() != 0);
    epc   = ev ? mq[0][63:32] : 32'h0;
    einst = ev ? mq[0][31:0] : NOP_INST;
    check_eq({tag, ".valid"}, {31'b0, id_valid}, {31'b0, ev});
    check_eq({tag, ".pc"}, id_pc, epc);
    check_eq({tag, ".inst"}, id_inst, einst);
    check_eq({tag, ".count"}, {29'b0, fb_count}, mq.size());
    check_eq({tag, ".stall"}, {31'b0, pc_stall}, {31'b0, (mq.size() == DEPTH)});
  endtask

  // One clock: model decides push/pop from pre-edge state, then outputs are compared.
  task automatic step(input string tag);
    logic do_push, do_pop;
    do_push = if_valid && (mq.size() < DEPTH) && !br_ctrl;
    do_pop  = (mq.size() != 0) && id_ready && !br_ctrl;
    if (do_pop) popped_pc.push_back(id_pc);
    @(posedge clk);
    if (br_ctrl) begin
      mq.delete();
    end else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back({if_pc, if_inst});
    end
    #1;
    check_model(tag);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic br, input logic rdy);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
    br_ctrl  = br;
    id_ready = rdy;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic flush_all();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step("flush_all");
    idle();
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b1;
    idle();
    #2;
    check_eq("rst.valid", {31'b0, id_valid}, 32'h0);
    check_eq("rst.count", {29'b0, fb_count}, 32'h0);
    check_eq("rst.inst", id_inst, NOP_INST);
    check_eq("rst.pc", id_pc, 32'h0);
    check_eq("rst.stall", {31'b0, pc_stall}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming with decode always ready.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0, 1'b1);
      step("stream");
      check_eq("stream.count1", {29'b0, fb_count}, 32'd1);
      check_eq("stream.inst", id_inst, 32'hA000_0000 + 32'(i));
      check_eq("stream.pc", id_pc, 32'(i * 4));
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step("stream.drain");
    check_eq("stream.empty", {31'b0, id_valid}, 32'h0);

    // Fill and stall, then full with simultaneous pop and push.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h40 + 32'(i * 4), 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
      step("fill");
      if (i == 3) check_eq("fill.stall4", {31'b0, pc_stall}, 32'h1);
    end
    check_eq("fill.count", {29'b0, fb_count}, 32'd4);
    check_eq("fill.head", id_pc, 32'h40);
    drive(1'b1, 32'h50, 32'hB000_0004, 1'b0, 1'b1);
    step("fullpop");
    check_eq("fullpop.count", {29'b0, fb_count}, 32'd3);
    check_eq("fullpop.stall", {31'b0, pc_stall}, 32'h0);
    check_eq("fullpop.head", id_pc, 32'h44);
    drive(1'b1, 32'h50, 32'hB000_0004, 1'b0, 1'b0);
    step("retry");
    check_eq("retry.count", {29'b0, fb_count}, 32'd4);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step("fill.drain");
    check_eq("fill.lastpc", popped_pc[popped_pc.size() - 1], 32'h50);
    idle();

    // Wrap-around with random decode readiness.
    popped_pc.delete();
    begin
      int k;
      k = 0;
      for (int cyc = 0; cyc < 200 && (k < 10 || mq.size() != 0); cyc++) begin
        logic acc;
        drive(k < 10, 32'h100 + 32'(k * 4), 32'hC000_0000 + 32'(k), 1'b0,
              1'($urandom_range(0, 1)));
        acc = if_valid && (mq.size() < DEPTH);
        step("wrap");
        if (acc) k++;
      end
      check_eq("wrap.npop", popped_pc.size(), 32'd10);
      for (int i = 0; i < 10 && i < popped_pc.size(); i++)
        check_eq("wrap.order", popped_pc[i], 32'h100 + 32'(i * 4));
    end
    idle();

    // Flush with a push and pop presented in the same cycle.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h180 + 32'(i * 4), 32'hD000_0000 + 32'(i), 1'b0, 1'b0);
      step("preflush");
    end
    check_eq("preflush.count", {29'b0, fb_count}, 32'd3);
    drive(1'b1, 32'h190, 32'hD000_0009, 1'b1, 1'b1);
    step("flush");
    check_eq("flush.count", {29'b0, fb_count}, 32'd0);
    check_eq("flush.valid", {31'b0, id_valid}, 32'h0);
    drive(1'b1, 32'h194, 32'hD000_000A, 1'b1, 1'b1);
    step("flush2");
    check_eq("flush2.count", {29'b0, fb_count}, 32'd0);
    drive(1'b1, 32'h200, 32'hE000_0000, 1'b0, 1'b0);
    step("postflush");
    check_eq("postflush.pc", id_pc, 32'h200);
    check_eq("postflush.inst", id_inst, 32'hE000_0000);
    idle();
    step("postflush.idle");
    flush_all();

    // Asynchronous reset mid-stream with three entries queued.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(i * 4), 32'hF000_0000 + 32'(i), 1'b0, 1'b0);
      step("prerst");
    end
    check_eq("prerst.count", {29'b0, fb_count}, 32'd3);
    idle();
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst.valid", {31'b0, id_valid}, 32'h0);
    check_eq("midrst.count", {29'b0, fb_count}, 32'h0);
    check_eq("midrst.inst", id_inst, NOP_INST);
    check_eq("midrst.stall", {31'b0, pc_stall}, 32'h0);
    mq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 32'h400, 32'h1234_5678, 1'b0, 1'b0);
    step("afterrst");
    check_eq("afterrst.pc", id_pc, 32'h400);
    idle();

    // Randomized traffic.
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive(($urandom_range(0, 9) < 7), $urandom, $urandom, ($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 1)));
      step("rand");
    end
    idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
